// File: rtl/multiboot_ctrl.sv
// Warmboot/multiboot sequencer: selects an image at runtime and fires SB_WARMBOOT after an arm delay.
// Latency: BOOT rises BOOT_DELAY_CYCLES+1 clocks after an accepted boot_req; req_err pulses 1 clock after a rejected one.
// Backpressure: none; requests outside IDLE are dropped, and cancel aborts only in ARM/DELAY.
//
// Ports: clk_48mhz, reset (sync, active-high); boot_req/boot_image request strobe and index;
//        boot_cancel aborts a pending boot; btn_n async active-low button; busy/req_err/led status;
//        warmboot_s1/s0/boot go straight to SB_WARMBOOT.
// Option: define MULTIBOOT_BTN_EN to build the button synchroniser and hold-to-boot counter.
module multiboot_ctrl #(
  parameter int NUM_IMAGES        = 4,
  parameter int DEFAULT_IMAGE     = 1,
  parameter int BOOT_DELAY_CYCLES = 48000,
  parameter int FIRE_CYCLES       = 4,
  parameter int HOLD_CYCLES       = 96000,
  parameter int LED_DIV_BIT       = 21
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  input  logic       boot_cancel,
  input  logic       btn_n,
  output logic       busy,
  output logic       req_err,
  output logic       led,
  output logic       warmboot_s1,
  output logic       warmboot_s0,
  output logic       warmboot_boot
);

  localparam int DLY_W   = $clog2(BOOT_DELAY_CYCLES) + 1;
  localparam int FIRE_W  = $clog2(FIRE_CYCLES) + 1;
  localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int LED_BIT = (LED_DIV_BIT < DLY_W) ? LED_DIV_BIT : 0;

  // One-hot so that warmboot_boot and busy decode from single flop bits.
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ARM   = 5'b00010,
    S_DELAY = 5'b00100,
    S_FIRE  = 5'b01000,
    S_HALT  = 5'b10000
  } state_t;

  state_t            state, state_nxt;
  logic [DLY_W-1:0]  delay_cnt;
  logic [FIRE_W-1:0] fire_cnt;
  logic [1:0]        image;
  logic              btn_trig;
  logic [1:0]        start_img;
  logic              img_ok;
  logic              delay_done;

  // boot_req takes priority over a simultaneous button trigger.
  always_comb begin
    start_img = boot_req ? boot_image : 2'(DEFAULT_IMAGE);
    img_ok    = ({1'b0, start_img} < 3'(NUM_IMAGES));
  end

  // Counter holds the remaining DELAY cycles; leave on the edge where it reaches 0.
  assign delay_done = (delay_cnt <= DLY_W'(1));

`ifdef MULTIBOOT_BTN_EN
  logic [1:0]        btn_sync;
  logic [HOLD_W-1:0] hold_cnt;

  // Counter saturates at HOLD_CYCLES, so a held button triggers once and must be released.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      btn_sync <= 2'b11;
      hold_cnt <= '0;
    end else begin
      btn_sync <= {btn_sync[0], btn_n};
      if (btn_sync[1])
        hold_cnt <= '0;
      else if (hold_cnt != HOLD_W'(HOLD_CYCLES))
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign btn_trig = ~btn_sync[1] && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
`else
  logic unused_btn;
  assign unused_btn = btn_n;
  assign btn_trig   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_48mhz) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if ((boot_req || btn_trig) && img_ok) state_nxt = S_ARM;
      S_ARM:   state_nxt = boot_cancel ? S_IDLE : S_DELAY;
      S_DELAY: begin
        if (boot_cancel)     state_nxt = S_IDLE;
        else if (delay_done) state_nxt = S_FIRE;
      end
      S_FIRE:  if (fire_cnt == FIRE_W'(FIRE_CYCLES - 1)) state_nxt = S_HALT;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy          = (state != S_IDLE);
    warmboot_boot = (state == S_FIRE);
    warmboot_s1   = image[1];
    warmboot_s0   = image[0];
    case (state)
      S_IDLE:         led = 1'b0;
      S_ARM, S_DELAY: led = delay_cnt[LED_BIT];
      default:        led = 1'b1;
    endcase
  end

  // Counters, image latch and error pulse
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      delay_cnt <= '0;
      fire_cnt  <= '0;
      image     <= 2'(DEFAULT_IMAGE);
      req_err   <= 1'b0;
    end else begin
      req_err <= (state == S_IDLE) && boot_req && !img_ok;

      if ((state == S_IDLE) && (boot_req || btn_trig) && img_ok)
        image <= start_img;

      case (state)
        S_ARM:   delay_cnt <= boot_cancel ? '0 : DLY_W'(BOOT_DELAY_CYCLES - 1);
        S_DELAY: delay_cnt <= (boot_cancel || delay_done) ? '0 : delay_cnt - 1'b1;
        default: delay_cnt <= '0;
      endcase

      if (state == S_FIRE) fire_cnt <= fire_cnt + 1'b1;
      else                 fire_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_multiboot_ctrl.sv
module tb_multiboot_ctrl;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic       boot_req;
  logic [1:0] boot_image;
  logic       boot_cancel;
  logic       btn_n;
  logic       busy;
  logic       req_err;
  logic       led;
  logic       warmboot_s1;
  logic       warmboot_s0;
  logic       warmboot_boot;

  int tests = 0;
  int fails = 0;

`ifdef MULTIBOOT_BTN_EN
  localparam logic BTN_EN = 1'b1;
`else
  localparam logic BTN_EN = 1'b0;
`endif

  multiboot_ctrl #(
    .NUM_IMAGES(3),
    .DEFAULT_IMAGE(1),
    .BOOT_DELAY_CYCLES(16),
    .FIRE_CYCLES(4),
    .HOLD_CYCLES(8),
    .LED_DIV_BIT(21)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset(reset),
    .boot_req(boot_req),
    .boot_image(boot_image),
    .boot_cancel(boot_cancel),
    .btn_n(btn_n),
    .busy(busy),
    .req_err(req_err),
    .led(led),
    .warmboot_s1(warmboot_s1),
    .warmboot_s0(warmboot_s0),
    .warmboot_boot(warmboot_boot)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic tick;
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic do_reset;
    reset       = 1'b1;
    boot_req    = 1'b0;
    boot_image  = 2'd0;
    boot_cancel = 1'b0;
    btn_n       = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Returns one cycle after the request cycle (t+1).
  task automatic send_req(input logic [1:0] img);
    boot_req   = 1'b1;
    boot_image = img;
    tick();
    boot_req   = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (req_err !== 1'b0) begin fails++; $display("FAIL reset_req_err: got %b want 0", req_err); end
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL reset_led: got %b want 0", led); end
    tests++; if (warmboot_boot !== 1'b0) begin fails++; $display("FAIL reset_boot: got %b want 0", warmboot_boot); end
    tests++; if ({warmboot_s1, warmboot_s0} !== 2'b01) begin fails++; $display("FAIL reset_image: got %b want 01", {warmboot_s1, warmboot_s0}); end
  endtask

  task automatic test_image_boot;
    logic exp;
    do_reset();
    send_req(2'd2);
    tests++; if ({warmboot_s1, warmboot_s0} !== 2'b10) begin fails++; $display("FAIL boot_image_latch: got %b want 10", {warmboot_s1, warmboot_s0}); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL boot_busy_arm: got %b want 1", busy); end
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL boot_led_arm: got %b want 0", led); end
    for (int k = 2; k <= 22; k++) begin
      tick();
      exp = (k >= 17) && (k <= 20);
      tests++; if (warmboot_boot !== exp) begin fails++; $display("FAIL boot_timing t+%0d: got %b want %b", k, warmboot_boot, exp); end
      if (k == 2) begin
        tests++; if (led !== 1'b1) begin fails++; $display("FAIL boot_led_delay15: got %b want 1", led); end
      end
      if (k == 3) begin
        tests++; if (led !== 1'b0) begin fails++; $display("FAIL boot_led_delay14: got %b want 0", led); end
      end
    end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL halt_busy: got %b want 1", busy); end
    tests++; if (led !== 1'b1) begin fails++; $display("FAIL halt_led: got %b want 1", led); end
    tests++; if ({warmboot_s1, warmboot_s0} !== 2'b10) begin fails++; $display("FAIL halt_image: got %b want 10", {warmboot_s1, warmboot_s0}); end
  endtask

  task automatic test_invalid;
    do_reset();
    send_req(2'd3);
    tests++; if (req_err !== 1'b1) begin fails++; $display("FAIL invalid_err: got %b want 1", req_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL invalid_busy: got %b want 0", busy); end
    tests++; if ({warmboot_s1, warmboot_s0} !== 2'b01) begin fails++; $display("FAIL invalid_image: got %b want 01", {warmboot_s1, warmboot_s0}); end
    tick();
    tests++; if (req_err !== 1'b0) begin fails++; $display("FAIL invalid_err_width: got %b want 0", req_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL invalid_busy_later: got %b want 0", busy); end
  endtask

  task automatic test_cancel_race;
    logic seen;
    do_reset();
    send_req(2'd2);
    repeat (15) tick();          // now at t+16, last DELAY cycle
    boot_cancel = 1'b1;
    tick();
    boot_cancel = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cancel_busy: got %b want 0", busy); end
    seen = warmboot_boot;
    repeat (10) begin
      tick();
      seen = seen | warmboot_boot;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL cancel_no_boot: got %b want 0", seen); end
    send_req(2'd0);
    tests++; if ({warmboot_s1, warmboot_s0} !== 2'b00) begin fails++; $display("FAIL cancel_rereq_image: got %b want 00", {warmboot_s1, warmboot_s0}); end
    repeat (15) tick();          // t+16
    tests++; if (warmboot_boot !== 1'b0) begin fails++; $display("FAIL rereq_boot_early: got %b want 0", warmboot_boot); end
    tick();                      // t+17
    tests++; if (warmboot_boot !== 1'b1) begin fails++; $display("FAIL rereq_boot: got %b want 1", warmboot_boot); end
    boot_cancel = 1'b1;
    tick();                      // t+18, cancel ignored in FIRE
    boot_cancel = 1'b0;
    tests++; if (warmboot_boot !== 1'b1) begin fails++; $display("FAIL fire_cancel_boot: got %b want 1", warmboot_boot); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL fire_cancel_busy: got %b want 1", busy); end
  endtask

  task automatic test_ignored_req;
    do_reset();
    send_req(2'd2);
    repeat (4) tick();           // t+5, in DELAY
    boot_req   = 1'b1;
    boot_image = 2'd0;
    tick();                      // t+6
    boot_image = 2'd3;
    tick();                      // t+7
    boot_req   = 1'b0;
    tests++; if ({warmboot_s1, warmboot_s0} !== 2'b10) begin fails++; $display("FAIL ignored_image: got %b want 10", {warmboot_s1, warmboot_s0}); end
    tests++; if (req_err !== 1'b0) begin fails++; $display("FAIL ignored_err: got %b want 0", req_err); end
    repeat (10) tick();          // t+17
    tests++; if (warmboot_boot !== 1'b1) begin fails++; $display("FAIL ignored_boot: got %b want 1", warmboot_boot); end
    tests++; if ({warmboot_s1, warmboot_s0} !== 2'b10) begin fails++; $display("FAIL ignored_image_fire: got %b want 10", {warmboot_s1, warmboot_s0}); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    send_req(2'd2);
    repeat (17) tick();          // t+18, FIRE cycle 2
    tests++; if (warmboot_boot !== 1'b1) begin fails++; $display("FAIL midreset_pre_boot: got %b want 1", warmboot_boot); end
    reset = 1'b1;
    tick();
    tests++; if (warmboot_boot !== 1'b0) begin fails++; $display("FAIL midreset_boot: got %b want 0", warmboot_boot); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
    tests++; if ({warmboot_s1, warmboot_s0} !== 2'b01) begin fails++; $display("FAIL midreset_image: got %b want 01", {warmboot_s1, warmboot_s0}); end
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL midreset_led: got %b want 0", led); end
    reset = 1'b0;
    tick();
    tests++; if (warmboot_boot !== 1'b0) begin fails++; $display("FAIL midreset_after: got %b want 0", warmboot_boot); end
  endtask

  task automatic test_button;
    logic seen;
    do_reset();
    btn_n = 1'b0;
    repeat (7) tick();
    btn_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | busy;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL btn_short_busy: got %b want 0", seen); end
    btn_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 9) btn_n = 1'b1;
      seen = seen | warmboot_boot;
    end
    tests++; if (seen !== BTN_EN) begin fails++; $display("FAIL btn_hold_boot: got %b want %b", seen, BTN_EN); end
    tests++; if (busy !== BTN_EN) begin fails++; $display("FAIL btn_hold_busy: got %b want %b", busy, BTN_EN); end
    tests++; if ({warmboot_s1, warmboot_s0} !== 2'b01) begin fails++; $display("FAIL btn_image: got %b want 01", {warmboot_s1, warmboot_s0}); end
  endtask

  initial begin
    test_reset();
    test_image_boot();
    test_invalid();
    test_cancel_race();
    test_ignored_req();
    test_mid_reset();
    test_button();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
